// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage RV32I core.
// Latency: one cycle ID->EX; stall_o is combinational from EX-slot state and ID controls.
// Backpressure: hold_i freezes the register; a load-use hazard stalls IF/ID and inserts one bubble.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_reg_write,
    input  logic              id_alu_src,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic [2:0]        id_alu_op,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_alu_src,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic [2:0]        ex_alu_op,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              mem_read;
        logic [2:0]        alu_op;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7b5;
    } ex_bundle_t;

    ex_bundle_t ex_q;
    ex_bundle_t id_d;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       lu;

    always_comb begin
        uses_rs1 = id_reg_write | id_mem_write | id_branch;
        uses_rs2 = (uses_rs1 & ~id_alu_src) | id_mem_write;
        // Bubbles and x0 destinations can never feed a stale load result.
        lu = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0)
           & ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));
    end

    assign stall_o = hold_i | (lu & ~flush_i);

    always_comb begin
        id_d            = '0;
        id_d.valid      = 1'b1;
        id_d.reg_write  = id_reg_write;
        id_d.alu_src    = id_alu_src;
        id_d.mem_write  = id_mem_write;
        id_d.mem_to_reg = id_mem_to_reg;
        id_d.branch     = id_branch;
        id_d.mem_read   = id_mem_read;
        id_d.alu_op     = id_alu_op;
        id_d.pc         = id_pc;
        id_d.rs1_data   = id_rs1_data;
        id_d.rs2_data   = id_rs2_data;
        id_d.imm        = id_imm;
        id_d.rs1        = id_rs1;
        id_d.rs2        = id_rs2;
        id_d.rd         = id_rd;
        id_d.funct3     = id_funct3;
        id_d.funct7b5   = id_funct7b5;
    end

    // Hold outranks flush: the flush source keeps flush_i high until hold drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            ex_q.alu_op <= 3'b111;
        end else if (hold_i) begin
            ex_q <= ex_q;
        end else if (flush_i | lu) begin
            ex_q        <= '0;
            ex_q.alu_op <= 3'b111;
        end else begin
            ex_q <= id_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7b5   = ex_q.funct7b5;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage: normal flow, load-use, exemptions, flush, hold, reset.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Control bundle order: {reg_write, alu_src, mem_write, mem_to_reg, branch, mem_read}
    localparam logic [5:0]  C_R  = 6'b100000;
    localparam logic [5:0]  C_LW = 6'b110101;
    localparam logic [5:0]  C_SW = 6'b011000;
    localparam logic [5:0]  C_AI = 6'b110000;
    localparam logic [31:0] IMM_X = 32'hA5A5_0000;
    localparam logic [1:0]  K_LD = 2'd0, K_BUB = 2'd1, K_KEEP = 2'd2;

    logic clk = 1'b0;
    logic rst;
    logic id_reg_write, id_alu_src, id_mem_write, id_mem_to_reg, id_branch, id_mem_read;
    logic [2:0] id_alu_op, id_funct3;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic id_funct7b5, flush_i, hold_i;
    logic stall_o, ex_valid;
    logic ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_to_reg, ex_branch, ex_mem_read;
    logic [2:0] ex_alu_op, ex_funct3;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic ex_funct7b5;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .id_reg_write(id_reg_write), .id_alu_src(id_alu_src), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_alu_op(id_alu_op), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .flush_i(flush_i), .hold_i(hold_i),
        .stall_o(stall_o), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_alu_op(ex_alu_op), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5)
    );

    typedef struct {
        logic [5:0]  ctl;
        logic [2:0]  aop;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, pc;
        logic        flush, hold;
        logic        es;     // expected stall_o before the edge
        logic [1:0]  kind;   // expected EX contents after the edge
    } vec_t;

    typedef struct {
        logic        valid;
        logic [5:0]  ctl;
        logic [2:0]  aop;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
    } exp_t;

    vec_t tv[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [5:0] ctl, input logic [2:0] aop,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc,
                                input logic flush, input logic hold, input logic es,
                                input logic [1:0] kind);
        vec_t v;
        v.ctl = ctl; v.aop = aop; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.d1 = d1; v.d2 = d2; v.pc = pc; v.flush = flush; v.hold = hold;
        v.es = es; v.kind = kind;
        return v;
    endfunction

    function automatic exp_t bubble_exp();
        exp_t b;
        b.valid = 1'b0; b.ctl = '0; b.aop = 3'b111; b.pc = '0; b.d1 = '0; b.d2 = '0;
        b.imm = '0; b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.f3 = '0; b.f7 = 1'b0;
        return b;
    endfunction

    function automatic exp_t load_exp(input vec_t v);
        exp_t l;
        l.valid = 1'b1; l.ctl = v.ctl; l.aop = v.aop; l.pc = v.pc; l.d1 = v.d1; l.d2 = v.d2;
        l.imm = v.pc ^ IMM_X; l.rs1 = v.rs1; l.rs2 = v.rs2; l.rd = v.rd;
        l.f3 = v.pc[4:2]; l.f7 = v.pc[3];
        return l;
    endfunction

    task automatic drive(input vec_t v);
        {id_reg_write, id_alu_src, id_mem_write, id_mem_to_reg, id_branch, id_mem_read} = v.ctl;
        id_alu_op = v.aop; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_rs1_data = v.d1; id_rs2_data = v.d2; id_pc = v.pc; id_imm = v.pc ^ IMM_X;
        id_funct3 = v.pc[4:2]; id_funct7b5 = v.pc[3];
        flush_i = v.flush; hold_i = v.hold;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_ex(input string tag);
        chk({tag, " valid"},    32'(ex_valid), 32'(e.valid));
        chk({tag, " ctl"},      32'({ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_to_reg,
                                     ex_branch, ex_mem_read}), 32'(e.ctl));
        chk({tag, " alu_op"},   32'(ex_alu_op), 32'(e.aop));
        chk({tag, " pc"},       ex_pc, e.pc);
        chk({tag, " rs1_data"}, ex_rs1_data, e.d1);
        chk({tag, " rs2_data"}, ex_rs2_data, e.d2);
        chk({tag, " imm"},      ex_imm, e.imm);
        chk({tag, " rs1"},      32'(ex_rs1), 32'(e.rs1));
        chk({tag, " rs2"},      32'(ex_rs2), 32'(e.rs2));
        chk({tag, " rd"},       32'(ex_rd), 32'(e.rd));
        chk({tag, " funct3"},   32'(ex_funct3), 32'(e.f3));
        chk({tag, " funct7b5"}, 32'(ex_funct7b5), 32'(e.f7));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //       ctl   aop     rs1 rs2 rd  d1          d2          pc          fl hd st kind
        tv.push_back(mk(C_R,  3'b100, 3, 4, 5,  32'h10,   32'h20,   32'h100, 0, 0, 0, K_LD));   // R-type
        tv.push_back(mk(C_LW, 3'b000, 1, 9, 5,  32'h1000, 32'h0,    32'h104, 0, 0, 0, K_LD));   // lw x5
        tv.push_back(mk(C_R,  3'b100, 6, 5, 7,  32'h66,   32'h55,   32'h108, 0, 0, 1, K_BUB));  // add uses x5 via rs2
        tv.push_back(mk(C_R,  3'b100, 6, 5, 7,  32'h66,   32'h55,   32'h108, 0, 0, 0, K_LD));
        tv.push_back(mk(C_LW, 3'b000, 2, 0, 0,  32'h2000, 32'h0,    32'h10c, 0, 0, 0, K_LD));   // lw x0
        tv.push_back(mk(C_R,  3'b100, 0, 0, 8,  32'h0,    32'h0,    32'h110, 0, 0, 0, K_LD));   // use x0: no stall
        tv.push_back(mk(C_LW, 3'b000, 1, 9, 5,  32'h1000, 32'h0,    32'h114, 0, 0, 0, K_LD));
        tv.push_back(mk(C_AI, 3'b101, 6, 5, 9,  32'h66,   32'h77,   32'h118, 0, 0, 0, K_LD));   // addi rs2 field=5
        tv.push_back(mk(C_LW, 3'b000, 1, 9, 5,  32'h1000, 32'h0,    32'h11c, 0, 0, 0, K_LD));
        tv.push_back(mk(C_SW, 3'b000, 2, 5, 0,  32'h3000, 32'h99,   32'h120, 0, 0, 1, K_BUB));  // sw rs2=5
        tv.push_back(mk(C_SW, 3'b000, 2, 5, 0,  32'h3000, 32'h99,   32'h120, 0, 0, 0, K_LD));
        tv.push_back(mk(C_LW, 3'b000, 1, 9, 5,  32'h1000, 32'h0,    32'h124, 0, 0, 0, K_LD));
        tv.push_back(mk(C_R,  3'b100, 6, 5, 7,  32'h66,   32'h55,   32'h128, 1, 0, 0, K_BUB));  // flush beats lu
        tv.push_back(mk(C_R,  3'b100, 6, 5, 7,  32'h66,   32'h55,   32'h128, 0, 0, 0, K_LD));
        tv.push_back(mk(C_LW, 3'b000, 1, 9, 5,  32'h1000, 32'h0,    32'h12c, 0, 0, 0, K_LD));
        tv.push_back(mk(C_LW, 3'b000, 5, 9, 6,  32'h5000, 32'h0,    32'h130, 0, 0, 1, K_BUB));  // back-to-back loads
        tv.push_back(mk(C_LW, 3'b000, 5, 9, 6,  32'h5000, 32'h0,    32'h130, 0, 0, 0, K_LD));
        tv.push_back(mk(C_R,  3'b100, 6, 1, 7,  32'h44,   32'h11,   32'h134, 0, 0, 1, K_BUB));
        tv.push_back(mk(C_R,  3'b100, 6, 1, 7,  32'h44,   32'h11,   32'h134, 0, 0, 0, K_LD));
        tv.push_back(mk(C_R,  3'b100, 1, 2, 10, 32'hAA,   32'hBB,   32'h208, 0, 1, 1, K_KEEP)); // hold x3
        tv.push_back(mk(C_R,  3'b100, 1, 2, 10, 32'hAA,   32'hBB,   32'h208, 1, 1, 1, K_KEEP));
        tv.push_back(mk(C_R,  3'b100, 1, 2, 10, 32'hAA,   32'hBB,   32'h208, 1, 1, 1, K_KEEP));
        tv.push_back(mk(C_R,  3'b100, 1, 2, 10, 32'hAA,   32'hBB,   32'h208, 1, 0, 0, K_BUB));  // release, flush high
        tv.push_back(mk(C_R,  3'b100, 1, 2, 10, 32'hAA,   32'hBB,   32'h208, 0, 0, 0, K_LD));

        rst = 1'b1;
        drive(mk(6'b0, 3'b0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, K_BUB));
        #12;
        e = bubble_exp();
        chk("reset stall", 32'(stall_o), 32'd0);
        check_ex("reset");
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            #2;
            chk($sformatf("v%0d stall", i), 32'(stall_o), 32'(tv[i].es));
            @(posedge clk);
            #1;
            if (tv[i].kind == K_LD)       e = load_exp(tv[i]);
            else if (tv[i].kind == K_BUB) e = bubble_exp();
            check_ex($sformatf("v%0d", i));
        end

        // Asynchronous reset in mid-cycle clears a live instruction immediately.
        drive(mk(C_R, 3'b010, 11, 12, 13, 32'hDEAD, 32'hBEEF, 32'h300, 0, 0, 0, K_LD));
        @(posedge clk);
        #1;
        e = load_exp(mk(C_R, 3'b010, 11, 12, 13, 32'hDEAD, 32'hBEEF, 32'h300, 0, 0, 0, K_LD));
        check_ex("pre-reset");
        #3;
        rst = 1'b1;
        #1;
        e = bubble_exp();
        check_ex("mid reset");
        chk("mid reset stall", 32'(stall_o), 32'd0);
        hold_i = 1'b1;
        #1;
        chk("reset hold stall", 32'(stall_o), 32'd1);
        hold_i = 1'b0;
        @(posedge clk);
        #1;
        check_ex("reset held");
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, with integrated load-use hazard detection.
- Captures the main decoder control bundle, register-file read data, the immediate, PC, register specifiers and ALU-control function bits at the end of ID, and presents them to EX.
- Generates the stall that freezes PC and IF/ID, and inserts bubbles on load-use hazards and branch flushes.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)
REG_AW, 5, register specifier width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
id_reg_write  in  1  decoder RegWrite
id_alu_src  in  1  decoder ALUSrc
id_mem_write  in  1  decoder MemWrite
id_mem_to_reg  in  1  decoder MemToReg
id_branch  in  1  decoder Branch
id_mem_read  in  1  decoder MemRead
id_alu_op  in  3  decoder ALUOp
id_pc  in  XLEN  PC of ID instruction
id_rs1_data  in  XLEN  register-file read port 1
id_rs2_data  in  XLEN  register-file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  REG_AW  rs1 specifier
id_rs2  in  REG_AW  rs2 specifier
id_rd  in  REG_AW  rd specifier
id_funct3  in  3  instr[14:12]
id_funct7b5  in  1  instr[30]
flush_i  in  1  branch taken, resolved in EX
hold_i  in  1  downstream busy: freeze this register
stall_o  out  1  freeze PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX slot holds a real instruction
ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_to_reg, ex_branch, ex_mem_read  out  1 each  registered controls
ex_alu_op  out  3  registered ALUOp
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered datapath
ex_rs1, ex_rs2, ex_rd  out  REG_AW each  registered specifiers
ex_funct3  out  3  registered funct3
ex_funct7b5  out  1  registered funct7 bit 5

Behaviour:
- Reset (async, any time, including mid-stall): all ex_* outputs = 0 except ex_alu_op = 3'b111; ex_valid = 0. stall_o is derived only from registered state and inputs, so it is 0 during reset unless hold_i = 1.
- Operand usage, decoded from the control inputs:
  - uses_rs1 = id_reg_write | id_mem_write | id_branch.
  - uses_rs2 = (uses_rs1 & ~id_alu_src) | id_mem_write.
- Load-use hazard:
  - lu = ex_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- Outputs and next state:
  - stall_o = hold_i | (lu & ~flush_i).
  - Bubble = all controls 0, ex_alu_op = 3'b111, ex_valid = 0; datapath and specifier fields = 0.
  - Each rising edge, first matching rule wins:
    1. hold_i = 1: every register keeps its value. flush_i is ignored; the source keeps flush asserted until hold drops.
    2. flush_i = 1: load bubble.
    3. lu = 1: load bubble. IF/ID is frozen via stall_o, so the same ID instruction re-presents next cycle.
    4. Otherwise: load all id_* fields; ex_valid = 1.
- Latency: one cycle from ID to EX. A load-use pair costs exactly one bubble: the next cycle the load sits in MEM, ex_mem_read becomes 0 and lu clears.
- Writes to rd = x0 never raise lu.
- ex_valid = 0 entries never raise lu, even if stale fields match.
- Back-to-back hazards: each lu instance inserts one bubble. No counter state beyond the register itself.
- No combinational path from id_* data to ex_* outputs.

Test Plan:
- Reset: assert rst mid-cycle while a real instruction is held -> outputs clear immediately; ex_alu_op = 3'b111; ex_valid = 0; stall_o = 0.
- Normal flow: R-type (reg_write = 1, alu_op = 3'b100, rs1 = 3, rs2 = 4, rd = 5, rs1_data = 0x10, rs2_data = 0x20) -> next edge ex_* equal inputs; ex_valid = 1; stall_o = 0 throughout.
- Load-use: lw x5 into EX, then ID add with rs2 = 5 -> stall_o = 1 for one cycle; next edge inserts a bubble (ex_valid = 0, ex_alu_op = 3'b111); following edge latches the add; stall_o = 0.
- Hazard exemptions:
  - lw x0 followed by use of x0 -> no stall.
  - lw x5 followed by addi with rs2 field = 5 (alu_src = 1) -> no stall.
  - lw x5 followed by sw with rs2 = 5 -> stall.
- Flush priority: flush_i = 1 in the same cycle as lu -> stall_o = 0; next edge inserts a bubble.
- Hold: hold_i = 1 for 3 cycles with a valid instruction in EX and flush_i pulsed during hold -> ex_* unchanged; stall_o = 1. After release with flush still high -> bubble.
